// File: rtl/packet_deserializer.sv
// packet_deserializer: assembles a 51-bit serial command frame (50 packet
// bits MSB first plus one even-parity bit) into a 50-bit packet word. The
// word is offered downstream through a single-entry buffer. Framing, parity
// and overflow errors are recorded in sticky status flags.
//
// Handshake: packet_valid high means packet holds an unconsumed word that
// stays stable until it is taken. A transfer happens on any rising edge where
// packet_valid && packet_ready. A commit on that same edge reloads the buffer,
// so packet_valid stays high.
module packet_deserializer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        ser_en,
  input  logic        ser_valid,
  input  logic        ser_data,
  output logic [49:0] packet,
  output logic        packet_valid,
  input  logic        packet_ready,
  input  logic        clear_status,
  output logic        frame_err,
  output logic        parity_err,
  output logic        overflow,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_t      state, state_d;
  logic [49:0] shift_q;
  logic [5:0]  bit_cnt;
  logic        par_q;
  logic [15:0] to_cnt;
  logic        eval_ok;     // completed frame had even parity
  logic        tail_clean;  // no stray strobe seen since evaluation

  logic strobe;
  logic start, take_bit, eval, commit, to_inc, tail_bad, frame_set;
  logic load, ovf_set, par_set;

  assign strobe    = ser_en && ser_valid;
  assign state_dbg = state;

  // Commit decisions. Only a frame that reached TAIL without stray strobes counts.
  assign load    = commit && tail_clean && eval_ok && (!packet_valid || packet_ready);
  assign ovf_set = commit && tail_clean && eval_ok && packet_valid && !packet_ready;
  assign par_set = commit && tail_clean && !eval_ok;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_d   = state;
    start     = 1'b0;
    take_bit  = 1'b0;
    eval      = 1'b0;
    commit    = 1'b0;
    to_inc    = 1'b0;
    tail_bad  = 1'b0;
    frame_set = 1'b0;
    case (state)
      IDLE: begin
        if (ser_en) begin
          start    = 1'b1;
          take_bit = strobe;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (!ser_en) begin
          frame_set = 1'b1;
          state_d   = IDLE;
        end else if (strobe) begin
          // Counter reaching 50 means this strobe carries the parity bit.
          if (bit_cnt == 6'd50) begin
            eval    = 1'b1;
            state_d = TAIL;
          end else begin
            take_bit = 1'b1;
          end
        end else if (to_cnt == TO_LIM) begin
          frame_set = 1'b1;
          state_d   = IDLE;
        end else begin
          to_inc = 1'b1;
        end
      end
      TAIL: begin
        if (!ser_en) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else if (strobe) begin
          frame_set = 1'b1;
          tail_bad  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register, bit counter, running parity, gap timer and frame verdict.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      par_q      <= 1'b0;
      to_cnt     <= '0;
      eval_ok    <= 1'b0;
      tail_clean <= 1'b0;
    end else begin
      if (take_bit) shift_q <= {shift_q[48:0], ser_data};

      if (start)         bit_cnt <= {5'd0, take_bit};
      else if (take_bit) bit_cnt <= bit_cnt + 6'd1;

      if (start)         par_q <= take_bit & ser_data;
      else if (take_bit) par_q <= par_q ^ ser_data;

      if (start || strobe) to_cnt <= '0;
      else if (to_inc)     to_cnt <= to_cnt + 16'd1;

      if (eval) begin
        eval_ok    <= ~(par_q ^ ser_data);
        tail_clean <= 1'b1;
      end else if (tail_bad) begin
        tail_clean <= 1'b0;
      end
    end
  end

  // Single-entry output buffer.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      packet       <= '0;
      packet_valid <= 1'b0;
    end else if (load) begin
      packet       <= shift_q;
      packet_valid <= 1'b1;
    end else if (packet_valid && packet_ready) begin
      packet_valid <= 1'b0;
    end
  end

  // Sticky status flags. A new error event wins over clear_status.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (frame_set)         frame_err <= 1'b1;
      else if (clear_status) frame_err <= 1'b0;
      if (par_set)           parity_err <= 1'b1;
      else if (clear_status) parity_err <= 1'b0;
      if (ovf_set)           overflow <= 1'b1;
      else if (clear_status) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_packet_deserializer.sv
// Bench for packet_deserializer: frame driver tasks, a delivery scoreboard
// fed at stimulus time and drained at every buffer transfer, and one task per
// scenario.
module tb_packet_deserializer;

  localparam int TO = 8;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        ser_en = 1'b0;
  logic        ser_valid = 1'b0;
  logic        ser_data = 1'b0;
  logic        packet_ready = 1'b0;
  logic        clear_status = 1'b0;
  logic [49:0] packet;
  logic        packet_valid;
  logic        frame_err;
  logic        parity_err;
  logic        overflow;
  logic [1:0]  state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  logic [49:0] exp_q[$];
  logic [49:0] exp_head;

  localparam logic [49:0] PKT_W = {2'b01, 4'd2, 4'hF, 8'h3C, 32'hDEADBEEF};

  // Clock and reset
  always #5 clk_in = ~clk_in;

  packet_deserializer #(.TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .ser_en(ser_en), .ser_valid(ser_valid),
    .ser_data(ser_data), .packet(packet), .packet_valid(packet_valid),
    .packet_ready(packet_ready), .clear_status(clear_status),
    .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow),
    .state_dbg(state_dbg)
  );

  // Scoreboard: every transfer must match the oldest expected packet
  always @(negedge clk_in) begin
    if (rst_n && packet_valid && packet_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL deliver_unexpected: got packet=%h, expected no delivery", packet);
      end else begin
        exp_head = exp_q.pop_front();
        if (packet !== exp_head) begin
          tests_failed++;
          $display("FAIL deliver_data: got packet=%h, expected %h", packet, exp_head);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one frame: nbits strobes from {pkt, parity}; zeros beyond bit 51.
  // Optional idle gap after gap_at strobes. Ends one edge after ser_en drops.
  task automatic drive_frame(input logic [49:0] pkt, input bit bad_par,
                             input int nbits, input int gap_at,
                             input int gap_len, input bit ready_pulse);
    logic [50:0] fr;
    fr = {pkt, (^pkt) ^ bad_par};
    ser_en = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      ser_valid = 1'b1;
      ser_data  = (i < 51) ? fr[50-i] : 1'b0;
      @(posedge clk_in); #1;
      if (i + 1 == gap_at) begin
        ser_valid = 1'b0;
        repeat (gap_len) begin @(posedge clk_in); #1; end
      end
    end
    ser_en = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
    if (ready_pulse) packet_ready = 1'b1;
    @(posedge clk_in); #1;
    if (ready_pulse) packet_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    @(posedge clk_in); #1;
    clear_status = 1'b0;
  endtask

  task automatic check_queue_empty(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_pending: %0d packets not delivered, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_in);
    #1;
    tests_run++;
    if ({packet, packet_valid, frame_err, parity_err, overflow, state_dbg} !== 56'd0) begin
      tests_failed++;
      $display("FAIL reset_values: got packet=%h v=%b fe=%b pe=%b ov=%b st=%0d, expected all 0",
               packet, packet_valid, frame_err, parity_err, overflow, state_dbg);
    end
    rst_n = 1'b1;
    @(posedge clk_in); #1;
  endtask

  task automatic test_write();
    packet_ready = 1'b1;
    exp_q.push_back(PKT_W);
    drive_frame(PKT_W, 1'b0, 51, 0, 0, 1'b0);
    tests_run++;
    if (packet_valid !== 1'b1 || packet !== PKT_W) begin
      tests_failed++;
      $display("FAIL write_latency: got v=%b packet=%h, expected v=1 packet=%h", packet_valid, packet, PKT_W);
    end
    tests_run++;
    if ({frame_err, parity_err, overflow} !== 3'b000) begin
      tests_failed++;
      $display("FAIL write_flags: got fe/pe/ov=%b, expected 000", {frame_err, parity_err, overflow});
    end
    @(posedge clk_in); #1;
    tests_run++;
    if (packet_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_one_cycle: got v=%b one cycle later, expected 0", packet_valid);
    end
    check_queue_empty("write");
  endtask

  task automatic test_parity();
    drive_frame(PKT_W, 1'b1, 51, 0, 0, 1'b0);
    tests_run++;
    if (parity_err !== 1'b1 || packet_valid !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL parity_bad: got pe=%b v=%b fe=%b, expected pe=1 v=0 fe=0", parity_err, packet_valid, frame_err);
    end
    exp_q.push_back(~PKT_W);
    drive_frame(~PKT_W, 1'b0, 51, 0, 0, 1'b0);
    tests_run++;
    if (packet_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_recover: got v=%b, expected 1", packet_valid);
    end
    @(posedge clk_in); #1;
    check_queue_empty("parity");
    pulse_clear();
  endtask

  task automatic test_framing();
    drive_frame(PKT_W, 1'b0, 20, 0, 0, 1'b0);
    tests_run++;
    if (frame_err !== 1'b1 || packet_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_short: got fe=%b v=%b, expected fe=1 v=0", frame_err, packet_valid);
    end
    pulse_clear();
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_clear: got fe=%b, expected 0", frame_err);
    end
    drive_frame(PKT_W, 1'b0, 52, 0, 0, 1'b0);
    tests_run++;
    if (frame_err !== 1'b1 || packet_valid !== 1'b0 || parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_long: got fe=%b v=%b pe=%b, expected fe=1 v=0 pe=0", frame_err, packet_valid, parity_err);
    end
    @(posedge clk_in); #1;
    check_queue_empty("framing");
    pulse_clear();
  endtask

  task automatic test_timeout();
    logic [49:0] p;
    ser_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ser_valid = 1'b1; ser_data = 1'($urandom_range(0, 1));
      @(posedge clk_in); #1;
    end
    ser_valid = 1'b0;
    repeat (TO) begin @(posedge clk_in); #1; end
    tests_run++;
    if (frame_err !== 1'b0 || state_dbg !== 2'd1) begin
      tests_failed++;
      $display("FAIL timeout_early: got fe=%b st=%0d after %0d idle, expected fe=0 st=1", frame_err, state_dbg, TO);
    end
    @(posedge clk_in); #1;
    tests_run++;
    if (frame_err !== 1'b1 || state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL timeout_abort: got fe=%b st=%0d, expected fe=1 st=0", frame_err, state_dbg);
    end
    ser_en = 1'b0;
    @(posedge clk_in); #1;
    pulse_clear();
    // Gap of exactly TIMEOUT idle cycles is tolerated.
    p = {18'($urandom), 32'($urandom)};
    exp_q.push_back(p);
    drive_frame(p, 1'b0, 51, 10, TO, 1'b0);
    tests_run++;
    if (packet_valid !== 1'b1 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_gap_ok: got v=%b fe=%b, expected v=1 fe=0", packet_valid, frame_err);
    end
    @(posedge clk_in); #1;
    check_queue_empty("timeout");
  endtask

  task automatic test_back_to_back();
    logic [49:0] pa, pb, pc, pd;
    pa = {18'($urandom), 32'($urandom)};
    pb = ~pa;
    pc = {2'b11, 16'($urandom), 32'($urandom)};
    pd = {2'b00, 16'($urandom), 32'($urandom)};
    packet_ready = 1'b0;
    exp_q.push_back(pa);
    drive_frame(pa, 1'b0, 51, 0, 0, 1'b0);
    drive_frame(pb, 1'b0, 51, 0, 0, 1'b0);
    tests_run++;
    if (packet !== pa || packet_valid !== 1'b1 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_overflow: got packet=%h v=%b ov=%b, expected packet=%h v=1 ov=1", packet, packet_valid, overflow, pa);
    end
    pulse_clear();
    packet_ready = 1'b1;
    @(posedge clk_in); #1;
    packet_ready = 1'b0;
    tests_run++;
    if (packet_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: got v=%b, expected 0", packet_valid);
    end
    exp_q.push_back(pd);
    drive_frame(pd, 1'b0, 51, 0, 0, 1'b0);
    exp_q.push_back(pc);
    drive_frame(pc, 1'b0, 51, 0, 0, 1'b1);
    tests_run++;
    if (packet !== pc || packet_valid !== 1'b1 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_reload: got packet=%h v=%b ov=%b, expected packet=%h v=1 ov=0", packet, packet_valid, overflow, pc);
    end
    packet_ready = 1'b1;
    @(posedge clk_in); #1;
    check_queue_empty("back_to_back");
    // Streaming at full rate with ready held high.
    for (int k = 0; k < 4; k++) begin
      pa = {18'($urandom), 32'($urandom)};
      exp_q.push_back(pa);
      drive_frame(pa, 1'b0, 51, 0, 0, 1'b0);
    end
    @(posedge clk_in); #1;
    tests_run++;
    if ({frame_err, parity_err, overflow} !== 3'b000) begin
      tests_failed++;
      $display("FAIL stream_flags: got fe/pe/ov=%b, expected 000", {frame_err, parity_err, overflow});
    end
    check_queue_empty("stream");
  endtask

  task automatic test_mid_reset();
    logic [49:0] pf;
    packet_ready = 1'b0;
    drive_frame(PKT_W, 1'b0, 51, 0, 0, 1'b0);  // parked in buffer, discarded by reset
    ser_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ser_valid = 1'b1; ser_data = 1'($urandom_range(0, 1));
      @(posedge clk_in); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({packet, packet_valid, frame_err, parity_err, overflow, state_dbg} !== 56'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: got packet=%h v=%b fe=%b pe=%b ov=%b st=%0d, expected all 0",
               packet, packet_valid, frame_err, parity_err, overflow, state_dbg);
    end
    ser_en = 1'b0; ser_valid = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
    @(posedge clk_in); #1;
    packet_ready = 1'b1;
    pf = {18'($urandom), 32'($urandom)};
    exp_q.push_back(pf);
    drive_frame(pf, 1'b0, 51, 0, 0, 1'b0);
    tests_run++;
    if (packet_valid !== 1'b1 || packet !== pf || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_recover: got v=%b packet=%h fe=%b, expected v=1 packet=%h fe=0", packet_valid, packet, frame_err, pf);
    end
    @(posedge clk_in); #1;
    check_queue_empty("mid_reset");
  endtask

  initial begin
    test_reset();
    test_write();
    test_parity();
    test_framing();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    repeat (2) @(posedge clk_in);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
